// File: rtl/vram_write_scheduler_pkg.sv
// Shared GPU types: command opcodes, write-scheduler states and the
// packed command word carried through the command FIFO.
package gpu_pkg;

  localparam int VRAM_ADDR_WIDTH = 12;
  localparam int VRAM_DATA_WIDTH = 8;

  typedef enum logic {
    CMD_WRITE = 1'b0,
    CMD_CLEAR = 1'b1
  } cmd_op_t;

  typedef enum logic {
    WS_IDLE  = 1'b0,
    WS_CLEAR = 1'b1
  } wsched_state_t;

  typedef struct packed {
    cmd_op_t                    op;
    logic [VRAM_ADDR_WIDTH-1:0] address;
    logic [VRAM_DATA_WIDTH-1:0] data;
  } vram_cmd_t;

  localparam int VRAM_CMD_WIDTH = $bits(vram_cmd_t);

endpackage

// File: rtl/vram_write_scheduler_cmd_fifo.sv
// Synchronous command FIFO for the VRAM write scheduler. The head entry is
// visible combinationally so the scheduler can decide on it in the same
// cycle it pops. Flags and count come straight from registers.
module gpu_cmd_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [VRAM_CMD_WIDTH-1:0]    wdata_i,
  input  logic                         pop_i,
  output logic [VRAM_CMD_WIDTH-1:0]    rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [VRAM_CMD_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             count_q;
  logic                      do_push, do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  // Storage array: written on push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/vram_write_scheduler.sv
// VRAM write scheduler: queues CPU WRITE/CLEAR commands and drains them into
// the VRAM write port at one byte per clock. A CLEAR sweeps every address
// with a fill byte before later commands run.
// Build option: define VRAM_BLANK_ONLY_WRITE_EN to restrict pops and sweep
// writes to video blanking (video_enable = 0).
module vram_write_scheduler
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = VRAM_DATA_WIDTH,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_op,
  input  logic [ADDR_WIDTH-1:0]             cmd_address,
  input  logic [DATA_WIDTH-1:0]             cmd_data,
  input  logic                              video_enable,
  output logic                              vram_write_enable,
  output logic [ADDR_WIDTH-1:0]             vram_write_address,
  output logic [DATA_WIDTH-1:0]             vram_w_data,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  vram_cmd_t     push_cmd, head_cmd;
  logic [VRAM_CMD_WIDTH-1:0] head_bits;
  logic          fifo_full, fifo_empty, pop;
  logic          write_allowed;

  wsched_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0]     clear_cnt_q, clear_cnt_d;
  logic [DATA_WIDTH-1:0]     fill_q, fill_d;
  logic                      we_q, we_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;

`ifdef VRAM_BLANK_ONLY_WRITE_EN
  assign write_allowed = !video_enable;
`else
  // video_enable is kept on the port so both builds share one interface.
  logic unused_video_enable;
  assign unused_video_enable = video_enable;
  assign write_allowed = 1'b1;
`endif

  assign push_cmd.op      = cmd_op_t'(cmd_op);
  assign push_cmd.address = cmd_address;
  assign push_cmd.data    = cmd_data;
  assign head_cmd         = vram_cmd_t'(head_bits);

  gpu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid && !fifo_full),
    .wdata_i (push_cmd),
    .pop_i   (pop),
    .rdata_o (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state logic: dispatch the FIFO head in IDLE, sweep addresses in CLEAR.
  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    fill_d      = fill_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    pop         = 1'b0;
    case (state_q)
      WS_IDLE: begin
        if (!fifo_empty && write_allowed) begin
          pop = 1'b1;
          if (head_cmd.op == CMD_WRITE) begin
            we_d   = 1'b1;
            addr_d = head_cmd.address;
            data_d = head_cmd.data;
          end else begin
            fill_d      = head_cmd.data;
            clear_cnt_d = '0;
            state_d     = WS_CLEAR;
          end
        end
      end
      WS_CLEAR: begin
        if (write_allowed) begin
          we_d        = 1'b1;
          addr_d      = clear_cnt_q;
          data_d      = fill_q;
          clear_cnt_d = clear_cnt_q + ADDR_WIDTH'(1);
          if (clear_cnt_q == '1) begin
            state_d = WS_IDLE;
          end
        end
      end
      default: state_d = WS_IDLE;
    endcase
  end

  // State and registered VRAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WS_IDLE;
      clear_cnt_q <= '0;
      fill_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
      fill_q      <= fill_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign cmd_ready          = !fifo_full;
  assign busy               = !fifo_empty || (state_q != WS_IDLE);
  assign vram_write_enable  = we_q;
  assign vram_write_address = addr_q;
  assign vram_w_data        = data_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Self-checking bench for vram_write_scheduler: a transaction-level model
// (command queue plus sweep index) predicts every cycle's outputs.
module tb_vram_write_scheduler;

  localparam int AW        = 12;
  localparam int DW        = 8;
  localparam int DEPTH     = 8;
  localparam int CW        = $clog2(DEPTH + 1);
  localparam int VRAM_SIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_address;
  logic [DW-1:0] cmd_data;
  logic          video_enable;
  logic          vram_write_enable;
  logic [AW-1:0] vram_write_address;
  logic [DW-1:0] vram_w_data;
  logic          busy;
  logic [CW-1:0] fifo_count;

  vram_write_scheduler #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_op             (cmd_op),
    .cmd_address        (cmd_address),
    .cmd_data           (cmd_data),
    .video_enable       (video_enable),
    .vram_write_enable  (vram_write_enable),
    .vram_write_address (vram_write_address),
    .vram_w_data        (vram_w_data),
    .busy               (busy),
    .fifo_count         (fifo_count)
  );

  always #5 clk = ~clk;

  // ---------------- video_enable pattern generator ----------------
  int ve_mode  = 0;   // 0 low, 1 high, 2 random, 3 toggle 5 high / 5 low
  int ve_phase = 0;
  always @(negedge clk) begin
    case (ve_mode)
      0: video_enable = 1'b0;
      1: video_enable = 1'b1;
      2: video_enable = 1'($urandom % 2);
      default: begin
        video_enable = (ve_phase < 5);
        ve_phase     = (ve_phase + 1) % 10;
      end
    endcase
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    bit op;
    int addr;
    int data;
  } tb_cmd_t;

  tb_cmd_t mq[$];
  bit      sweeping   = 0;
  int      sweep_idx  = 0;
  int      fill       = 0;
  bit      exp_we     = 0;
  bit      exp_sweep  = 0;
  int      exp_addr   = 0;
  int      exp_data   = 0;
  bit      model_live = 0;

  always @(posedge clk) begin
    bit      push_now;
    bit      allowed;
    tb_cmd_t c;
    push_now = cmd_valid && (mq.size() < DEPTH);
    if (rst) begin
      mq.delete();
      sweeping   = 0;
      sweep_idx  = 0;
      exp_we     = 0;
      exp_sweep  = 0;
      exp_addr   = 0;
      exp_data   = 0;
      model_live = 1;
    end else begin
`ifdef VRAM_BLANK_ONLY_WRITE_EN
      allowed = !video_enable;
`else
      allowed = 1;
`endif
      exp_we    = 0;
      exp_sweep = 0;
      if (sweeping) begin
        if (allowed) begin
          exp_we    = 1;
          exp_sweep = 1;
          exp_addr  = sweep_idx;
          exp_data  = fill;
          if (sweep_idx == VRAM_SIZE - 1) sweeping = 0;
          sweep_idx = (sweep_idx + 1) % VRAM_SIZE;
        end
      end else if (mq.size() > 0 && allowed) begin
        c = mq.pop_front();
        if (c.op == 1'b0) begin
          exp_we   = 1;
          exp_addr = c.addr;
          exp_data = c.data;
        end else begin
          sweeping  = 1;
          sweep_idx = 0;
          fill      = c.data;
        end
      end
      if (push_now) begin
        c.op   = cmd_op;
        c.addr = int'(cmd_address);
        c.data = int'(cmd_data);
        mq.push_back(c);
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int hits [VRAM_SIZE];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at time %0t", name, $time);
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    @(negedge clk);
    if (model_live) begin
      chk("we",    vram_write_enable, exp_we);
      if (exp_we) begin
        chk("addr", vram_write_address, exp_addr);
        chk("data", vram_w_data, exp_data);
      end else begin
        chk("addr_hold", vram_write_address, exp_addr);
        chk("data_hold", vram_w_data, exp_data);
      end
      chk("count", fifo_count, mq.size());
      chk("ready", cmd_ready, mq.size() < DEPTH);
      chk("busy",  busy, (mq.size() != 0) || sweeping);
      if (exp_sweep && vram_write_enable)
        hits[int'(vram_write_address)]++;
    end
  endtask

  task automatic push_cmd(input bit op, input int addr, input int data);
    int waited = 0;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_address = addr[AW-1:0];
    cmd_data    = data[DW-1:0];
    while (!cmd_ready && waited < 20000) begin
      tick();
      waited++;
    end
    if (!cmd_ready) timeout_fail("push_wait");
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int waited = 0;
    while ((mq.size() != 0 || sweeping || exp_we) && waited < 20000) begin
      tick();
      waited++;
    end
    if (waited >= 20000) timeout_fail(name);
  endtask

  initial begin
    int ones;
    int waited;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0;
    cmd_address = '0; cmd_data = '0; video_enable = 1'b0;
    ve_mode = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("idle_we",    vram_write_enable, 0);
    chk("idle_addr",  vram_write_address, 0);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_busy",  busy, 0);
    chk("idle_count", fifo_count, 0);

    // Single WRITE: strobe appears two edges after acceptance.
    push_cmd(1'b0, 'h123, 'hA5);
    chk("lat_we_early", vram_write_enable, 0);
    tick();
    chk("lat_we",   vram_write_enable, 1);
    chk("lat_addr", vram_write_address, 'h123);
    chk("lat_data", vram_w_data, 'hA5);
    tick();
    chk("lat_we_off", vram_write_enable, 0);
    chk("lat_busy",   busy, 0);
    chk("lat_hold",   vram_w_data, 'hA5);

    // Randomized WRITE traffic with random video_enable.
    ve_mode = 2;
    for (int i = 0; i < 400; i++) begin
      cmd_valid   = 1'($urandom % 2);
      cmd_op      = 1'b0;
      cmd_address = AW'($urandom);
      cmd_data    = DW'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    ve_mode = 0;
    wait_idle("random_drain");

    // CLEAR with toggling video_enable, then fill the FIFO behind it.
    for (int a = 0; a < VRAM_SIZE; a++) hits[a] = 0;
    ve_mode = 3;
    push_cmd(1'b1, 0, 'h00);
    waited = 0;
    while (!sweeping && waited < 100) begin tick(); waited++; end
    if (!sweeping) timeout_fail("clear_start");
    push_cmd(1'b0, 'h005, 'h7F);
    for (int i = 0; i < 7; i++) push_cmd(1'b0, 'h100 + i, 'h10 + i);
    chk("full_count", fifo_count, 8);
    chk("full_ready", cmd_ready, 0);
    chk("full_busy",  busy, 1);
    push_cmd(1'b0, 'h200, 'h99);
    wait_idle("clear_drain");
    ones = 0;
    for (int a = 0; a < VRAM_SIZE; a++) if (hits[a] == 1) ones++;
    chk("sweep_cover", ones, VRAM_SIZE);

    // Reset in the middle of a sweep, with commands queued behind it.
    ve_mode = 0;
    push_cmd(1'b1, 0, 'h3C);
    for (int i = 0; i < 3; i++) push_cmd(1'b0, 'h300 + i, 'h55);
    waited = 0;
    while (!(sweeping && sweep_idx >= 'h200) && waited < 20000) begin tick(); waited++; end
    if (!sweeping) timeout_fail("sweep_reach");
    rst = 1'b1;
    tick();
    chk("rst_we",    vram_write_enable, 0);
    chk("rst_addr",  vram_write_address, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_ready", cmd_ready, 1);
    rst = 1'b0;
    tick();
    push_cmd(1'b1, 0, 'h11);
    waited = 0;
    while (!vram_write_enable && waited < 50) begin tick(); waited++; end
    if (!vram_write_enable) timeout_fail("restart_wait");
    chk("restart_addr", vram_write_address, 0);
    chk("restart_data", vram_w_data, 'h11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_write_scheduler.md
Name: vram_write_scheduler

Overview:
- Sequences CPU-originated writes into the VRAM write port (`vram_write_address`, `w_data`, plus a write enable) inside graphics_card. These signals are currently unused.
- Buffers incoming commands in a small FIFO and drains them one byte per clock.
- Supports a bulk CLEAR command that sweeps the whole VRAM with a fill byte.
- Write issue is optionally gated to video blanking, so VGA reads never collide with CPU writes.

Parameters:
- ADDR_WIDTH, 12, VRAM byte-address width (4096 bytes).
- DATA_WIDTH, 8, VRAM data width.
- FIFO_DEPTH, 8, command FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command; equals !fifo_full.
- cmd_op  input  1  0 = WRITE, 1 = CLEAR.
- cmd_address  input  ADDR_WIDTH  target byte address for WRITE; ignored for CLEAR.
- cmd_data  input  DATA_WIDTH  write byte (WRITE) or fill byte (CLEAR).
- video_enable  input  1  from vga_controller; 1 = active display.
- vram_write_enable  output  1  registered VRAM write strobe.
- vram_write_address  output  ADDR_WIDTH  registered VRAM write address.
- vram_w_data  output  DATA_WIDTH  registered VRAM write data.
- busy  output  1  FIFO non-empty, or FSM not in IDLE.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - vram_write_enable = 0, vram_write_address = 0, vram_w_data = 0.
  - fifo_count = 0, busy = 0, FSM = IDLE, clear counter = 0.
  - cmd_ready = 1 in the first cycle after reset.
- Handshake: a command is accepted on a clock edge where cmd_valid && cmd_ready. {cmd_op, cmd_address, cmd_data} is pushed into the FIFO.
- FIFO full/empty and simultaneous events:
  - Push and pop in the same cycle leave fifo_count unchanged.
  - A push is impossible when full, because cmd_ready = 0.
  - A pop never occurs when empty.
- write_allowed: 1 always, unless gated by the optional feature.
- FSM state IDLE:
  - FIFO non-empty, head op is WRITE, write_allowed: pop the entry. Next cycle vram_write_enable = 1 with the head's address and data. Stay in IDLE, so back-to-back writes run at one per cycle.
  - FIFO non-empty, head op is CLEAR, write_allowed: pop the entry, latch the fill byte, load clear counter = 0, go to CLEAR. No write is issued on this transition cycle.
  - Otherwise: vram_write_enable = 0.
- FSM state CLEAR:
  - Each cycle with write_allowed: issue a write of the fill byte at the clear counter, then increment the counter.
  - Each cycle without write_allowed: vram_write_enable = 0 and the counter holds.
  - After the write to address 2^ADDR_WIDTH-1 is issued, return to IDLE. The counter wraps to 0 and no extra write is issued.
  - The FIFO keeps accepting commands during CLEAR but is not drained.
- Latency: a WRITE accepted at edge N with the FIFO empty and write allowed gives vram_write_enable = 1 during the cycle after edge N+1 (2-cycle latency).
- Ordering: commands execute in strict FIFO order. A WRITE queued behind a CLEAR executes after the sweep, so it overwrites the fill value.
- Address/data hold: vram_write_address and vram_w_data hold their last values while vram_write_enable = 0.
- Reset mid-CLEAR: aborts immediately, discards the FIFO contents, and produces the reset values above on the next cycle.

Optional Feature:
- Macro: VRAM_BLANK_ONLY_WRITE_EN.
- Defined: write_allowed = !video_enable. Pops and CLEAR sweep writes occur only during blanking. When video_enable rises, a write already registered still completes that cycle; no new pop occurs.
- Undefined: write_allowed = 1 and video_enable is ignored. The port remains so the interface is identical in both builds.

Decomposition:
- Shared package gpu_pkg:
  - cmd_op_t enum {CMD_WRITE, CMD_CLEAR}.
  - wsched_state_t enum {WS_IDLE, WS_CLEAR}.
  - packed struct vram_cmd_t {op, address, data}.
  - constants VRAM_ADDR_WIDTH = 12, VRAM_DATA_WIDTH = 8.
- Sub-module gpu_cmd_fifo: synchronous FIFO of vram_cmd_t with push, pop, full, empty and count outputs. The FSM and output registers stay in the top module.

Test Plan:
- Reset, then idle → all outputs 0, cmd_ready = 1, busy = 0. Assert rst mid-stream → FIFO flushed and outputs 0 the next cycle.
- WRITE addr 0x123 data 0xA5, feature off → exactly one cycle of vram_write_enable = 1 with addr 0x123 and data 0xA5, two cycles after acceptance. busy returns to 0.
- Push 9 WRITEs back-to-back with FIFO_DEPTH = 8 while the drain is held off (feature on, video_enable = 1) → cmd_ready = 0 after the 8th push, fifo_count = 8. Drop video_enable → 8 consecutive writes in order, then the 9th is accepted.
- CLEAR fill 0x00 followed by WRITE 0x005 = 0x7F → 4096 writes covering 0x000–0xFFF, then one write of 0x7F to 0x005. FSM returns to IDLE.
- Feature on, CLEAR while video_enable toggles with period 10 (5 high, 5 low) → no write occurs while video_enable = 1. The counter holds across active periods and all 4096 addresses are written exactly once.
- Assert rst during CLEAR at counter 0x200 → sweep aborts, vram_write_enable = 0, and a new CLEAR restarts from 0x000.
